// File: rtl/encoder_pkg.sv
// Shared widths and encode helpers for the 4-to-2 priority encoder.
package encoder_pkg;

  localparam int unsigned ENC_IN_W  = 4;
  localparam int unsigned ENC_OUT_W = 2;

  function automatic logic [ENC_OUT_W-1:0] prio_enc(input logic [ENC_IN_W-1:0] i,
                                                    input logic msb_first);
    logic [ENC_OUT_W-1:0] idx;
    idx = 2'b00;
    if (msb_first) begin
      if      (i[3]) idx = 2'd3;
      else if (i[2]) idx = 2'd2;
      else if (i[1]) idx = 2'd1;
      else           idx = 2'd0;
    end else begin
      if      (i[0]) idx = 2'd0;
      else if (i[1]) idx = 2'd1;
      else if (i[2]) idx = 2'd2;
      else if (i[3]) idx = 2'd3;
      else           idx = 2'd0;
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcnt_ge2(input logic [ENC_IN_W-1:0] i);
    return (i & (i - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/encoder_4_2_core.sv
// Combinational encode of the request vector: index, valid and multi-request flag.
module encoder_4_2_core
  import encoder_pkg::*;
#(
  parameter int unsigned MSB_PRIORITY = 1
) (
  input  logic [ENC_IN_W-1:0]  req_i,
  output logic [ENC_OUT_W-1:0] y_nxt_o,
  output logic                 v_nxt_o,
  output logic                 multi_nxt_o
);

  always_comb begin
    y_nxt_o     = prio_enc(req_i, MSB_PRIORITY != 0);
    v_nxt_o     = |req_i;
    multi_nxt_o = popcnt_ge2(req_i);
  end

endmodule

// File: rtl/encoder_4_2.sv
// 4-to-2 priority encoder with registered index, valid and multi-request outputs.
module encoder_4_2
  import encoder_pkg::*;
#(
  parameter int unsigned MSB_PRIORITY = 1,
  parameter int unsigned HOLD_INVALID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ENC_IN_W-1:0]  I,
  output logic [ENC_OUT_W-1:0] Y,
  output logic                 V,
  output logic                 multi,
  output logic [ENC_OUT_W-1:0] y_nxt,
  output logic                 v_nxt
);

  logic                 multi_nxt;
  logic [ENC_OUT_W-1:0] y_d, y_q;
  logic                 v_d, v_q;
  logic                 multi_d, multi_q;

  encoder_4_2_core #(
    .MSB_PRIORITY(MSB_PRIORITY)
  ) u_core (
    .req_i      (I),
    .y_nxt_o    (y_nxt),
    .v_nxt_o    (v_nxt),
    .multi_nxt_o(multi_nxt)
  );

  always_comb begin
    y_d     = y_q;
    v_d     = v_q;
    multi_d = multi_q;
    if (en) begin
      v_d     = v_nxt;
      multi_d = multi_nxt;
      // An empty request either keeps the last index or lets the core's 2'b00 through.
      if (!v_nxt && (HOLD_INVALID != 0)) y_d = y_q;
      else                               y_d = y_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      v_q     <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      v_q     <= v_d;
      multi_q <= multi_d;
    end
  end

  assign Y     = y_q;
  assign V     = v_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_encoder_4_2.sv
// Randomized and directed bench for encoder_4_2 across all four parameter combinations.
module tb_encoder_4_2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;

  // Instance k: MSB_PRIORITY = (k[0] == 0), HOLD_INVALID = (k >= 2)
  logic [1:0] y[4];
  logic [1:0] y_nxt[4];
  logic       v[4];
  logic       v_nxt[4];
  logic       multi[4];

  logic [1:0] my[4];
  logic       mv[4];
  logic       mm[4];

  int n_cmp;
  int n_err;

  encoder_4_2 #(.MSB_PRIORITY(1), .HOLD_INVALID(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .I(req), .Y(y[0]), .V(v[0]), .multi(multi[0]),
    .y_nxt(y_nxt[0]), .v_nxt(v_nxt[0])
  );
  encoder_4_2 #(.MSB_PRIORITY(0), .HOLD_INVALID(0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .I(req), .Y(y[1]), .V(v[1]), .multi(multi[1]),
    .y_nxt(y_nxt[1]), .v_nxt(v_nxt[1])
  );
  encoder_4_2 #(.MSB_PRIORITY(1), .HOLD_INVALID(1)) u_hold (
    .clk(clk), .rst(rst), .en(en), .I(req), .Y(y[2]), .V(v[2]), .multi(multi[2]),
    .y_nxt(y_nxt[2]), .v_nxt(v_nxt[2])
  );
  encoder_4_2 #(.MSB_PRIORITY(0), .HOLD_INVALID(1)) u_lsb_hold (
    .clk(clk), .rst(rst), .en(en), .I(req), .Y(y[3]), .V(v[3]), .multi(multi[3]),
    .y_nxt(y_nxt[3]), .v_nxt(v_nxt[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: scan bit positions in priority order, count set bits arithmetically.
  function automatic logic [1:0] ref_idx(input logic [3:0] i, input bit msb);
    for (int n = 0; n < 4; n++) begin
      int b;
      b = msb ? 3 - n : n;
      if (i[b]) return 2'(b);
    end
    return 2'd0;
  endfunction

  function automatic int ref_pop(input logic [3:0] i);
    int c;
    c = 0;
    for (int b = 0; b < 4; b++) c += int'(i[b]);
    return c;
  endfunction

  task automatic step(input logic [3:0] i, input logic e, input logic r);
    req = i;
    en  = e;
    rst = r;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("y_nxt[%0d] I=%0h", k, i), 8'(y_nxt[k]), 8'(ref_idx(i, k % 2 == 0)));
      check_eq($sformatf("v_nxt[%0d] I=%0h", k, i), 8'(v_nxt[k]), 8'(i != 4'd0));
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (r) begin
        my[k] = 2'd0;
        mv[k] = 1'b0;
        mm[k] = 1'b0;
      end else if (e) begin
        mv[k] = (i != 4'd0);
        mm[k] = (ref_pop(i) >= 2);
        if (i != 4'd0)  my[k] = ref_idx(i, k % 2 == 0);
        else if (k < 2) my[k] = 2'd0;
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("Y[%0d] I=%0h en=%0b rst=%0b", k, i, e, r), 8'(y[k]), 8'(my[k]));
      check_eq($sformatf("V[%0d] I=%0h en=%0b rst=%0b", k, i, e, r), 8'(v[k]), 8'(mv[k]));
      check_eq($sformatf("multi[%0d] I=%0h", k, i), 8'(multi[k]), 8'(mm[k]));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < 4; k++) begin
      my[k] = 2'd0;
      mv[k] = 1'b0;
      mm[k] = 1'b0;
    end
    rst = 1'b1;
    en  = 1'b1;
    req = 4'hF;

    // Reset with a full request present: outputs must stay cleared.
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    check_eq("reset Y", 8'(y[0]), 8'h0);

    for (int n = 0; n < 16; n++) step(4'(n), 1'b1, 1'b0);

    step(4'hA, 1'b1, 1'b0);
    check_eq("lsb I=A", 8'(y[1]), 8'h1);
    step(4'hC, 1'b1, 1'b0);
    check_eq("lsb I=C", 8'(y[1]), 8'h2);
    step(4'h8, 1'b1, 1'b0);
    check_eq("lsb I=8", 8'(y[1]), 8'h3);
    step(4'h7, 1'b1, 1'b0);
    check_eq("lsb I=7", 8'(y[1]), 8'h0);

    // Enable low: registered outputs freeze while the combinational encode tracks I.
    step(4'h4, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step(4'h8, 1'b0, 1'b0);
      check_eq("hold Y", 8'(y[0]), 8'h2);
      check_eq("hold V", 8'(v[0]), 8'h1);
      check_eq("hold y_nxt", 8'(y_nxt[0]), 8'h3);
    end

    step(4'h8, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    check_eq("invalid force Y", 8'(y[0]), 8'h0);
    check_eq("invalid hold Y", 8'(y[2]), 8'h3);
    check_eq("invalid hold V", 8'(v[2]), 8'h0);

    step(4'h2, 1'b1, 1'b0);
    step(4'h2, 1'b1, 1'b1);
    check_eq("midreset Y", 8'(y[0]), 8'h0);
    check_eq("midreset V", 8'(v[0]), 8'h0);
    step(4'h2, 1'b1, 1'b0);
    check_eq("release Y", 8'(y[0]), 8'h1);
    check_eq("release V", 8'(v[0]), 8'h1);

    for (int n = 0; n < 300; n++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
